// File: rtl/raycast_core_stack.sv
// raycast_core_stack: LIFO of parent traversal contexts {idx, addr, t_enter, t_exit}
// with a registered top view, sticky overflow/underflow flags and single-cycle ops.
module raycast_core_stack #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int depth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [2:0]           push_idx_i,
  input  logic [aw-1:0]        push_addr_i,
  input  logic signed [dw-1:0] push_t_enter_i,
  input  logic signed [dw-1:0] push_t_exit_i,
  output logic [2:0]           top_idx_o,
  output logic [aw-1:0]        top_addr_o,
  output logic signed [dw-1:0] top_t_enter_o,
  output logic signed [dw-1:0] top_t_exit_o,
  output logic [$clog2(depth):0] level_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 pop_ack_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);
  localparam int iw = $clog2(depth);
  localparam int lw = iw + 1;
  typedef struct packed {
    logic [2:0]    idx;
    logic [aw-1:0] addr;
    logic [dw-1:0] te;
    logic [dw-1:0] tx;
  } entry_t;
  entry_t mem [depth];
  entry_t top_q, top_d, push_e;
  logic [lw-1:0] level_q, level_d;
  logic do_push, do_pop, do_repl, wr, ovf_d, udf_d, ack_d;
  logic [iw-1:0] wr_ptr;
  assign empty_o = level_q == '0;
  assign full_o  = level_q == lw'(depth);
  assign level_o = level_q;
  assign push_e  = '{push_idx_i, push_addr_i, push_t_enter_i, push_t_exit_i};
  assign {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o} = top_q;
  // push+pop on a non-empty stack rewrites the top in place; on an empty stack it degrades to a push
  always_comb begin
    do_repl = !clear_i && push_i && pop_i && !empty_o;
    do_push = !clear_i && push_i && (pop_i ? empty_o : !full_o);
    do_pop  = !clear_i && pop_i && !push_i && !empty_o;
    wr      = do_push || do_repl;
    wr_ptr  = do_repl ? iw'(level_q - lw'(1)) : iw'(level_q);
    level_d = clear_i ? '0 : do_push ? level_q + lw'(1) : do_pop ? level_q - lw'(1) : level_q;
    top_d   = clear_i ? '0 : wr ? push_e
            : do_pop ? (level_q >= lw'(2) ? mem[iw'(level_q - lw'(2))] : '0) : top_q;
    ovf_d   = !clear_i && (overflow_o || (push_i && !pop_i && full_o));
    udf_d   = !clear_i && (underflow_o || (pop_i && !push_i && empty_o));
    ack_d   = do_pop || do_repl;
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= push_e;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q     <= '0;
      top_q       <= '0;
      pop_ack_o   <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      level_q     <= level_d;
      top_q       <= top_d;
      pop_ack_o   <= ack_d;
      overflow_o  <= ovf_d;
      underflow_o <= udf_d;
    end
  end
endmodule

// File: tb/tb_raycast_core_stack.sv
// tb_raycast_core_stack: directed scenarios for the traversal context stack (depth 8).
module tb_raycast_core_stack;
  logic clk_i = 1'b0, rst_n_i = 1'b0, clear_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [2:0] push_idx_i = '0;
  logic [31:0] push_addr_i = '0;
  logic signed [31:0] push_t_enter_i = '0, push_t_exit_i = '0;
  logic [2:0] top_idx_o;
  logic [31:0] top_addr_o;
  logic signed [31:0] top_t_enter_o, top_t_exit_o;
  logic [3:0] level_o;
  logic empty_o, full_o, pop_ack_o, overflow_o, underflow_o;
  int n_vec = 0, n_err = 0;

  raycast_core_stack #(.dw(32), .aw(32), .depth(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i), .push_i(push_i), .pop_i(pop_i),
    .push_idx_i(push_idx_i), .push_addr_i(push_addr_i),
    .push_t_enter_i(push_t_enter_i), .push_t_exit_i(push_t_exit_i),
    .top_idx_o(top_idx_o), .top_addr_o(top_addr_o),
    .top_t_enter_o(top_t_enter_o), .top_t_exit_o(top_t_exit_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o), .pop_ack_o(pop_ack_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // one clocked operation; returns 1 time unit after the edge so outputs are settled
  task automatic op(input logic c, input logic pu, input logic po, input logic [2:0] idx,
                    input logic [31:0] addr, input logic [31:0] te, input logic [31:0] tx);
    clear_i = c; push_i = pu; pop_i = po;
    push_idx_i = idx; push_addr_i = addr; push_t_enter_i = te; push_t_exit_i = tx;
    @(posedge clk_i); #1;
    clear_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++; if (level_o !== 4'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level_o); end
    n_vec++; if ({empty_o, full_o, pop_ack_o, overflow_o, underflow_o} !== 5'b10000) begin n_err++; $display("FAIL rst_flags got %b want 10000", {empty_o, full_o, pop_ack_o, overflow_o, underflow_o}); end
    n_vec++; if ({top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o} !== '0) begin n_err++; $display("FAIL rst_top got %h want 0", {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o}); end
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    n_vec++; if (level_o !== 4'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL rst_hold level %0d empty %b want 0 1", level_o, empty_o); end
  endtask

  task automatic test_push();
    op(0, 1, 0, 3'd5, 32'h100, 32'd10, 32'd40);
    n_vec++; if (level_o !== 4'd1) begin n_err++; $display("FAIL push_level got %0d want 1", level_o); end
    n_vec++; if (top_idx_o !== 3'd5) begin n_err++; $display("FAIL push_idx got %0d want 5", top_idx_o); end
    n_vec++; if (top_addr_o !== 32'h100) begin n_err++; $display("FAIL push_addr got %h want 100", top_addr_o); end
    n_vec++; if (top_t_enter_o !== 32'sd10 || top_t_exit_o !== 32'sd40) begin n_err++; $display("FAIL push_t got %0d/%0d want 10/40", top_t_enter_o, top_t_exit_o); end
    n_vec++; if (empty_o !== 1'b0 || pop_ack_o !== 1'b0) begin n_err++; $display("FAIL push_flags empty %b ack %b want 0 0", empty_o, pop_ack_o); end
  endtask

  task automatic test_fill_overflow();
    op(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) op(0, 1, 0, 3'(i), 32'h200 + 32'(i), 32'(i * 3), -32'(i));
    n_vec++; if (full_o !== 1'b1 || level_o !== 4'd8 || overflow_o !== 1'b0) begin n_err++; $display("FAIL fill full %b level %0d ovf %b want 1 8 0", full_o, level_o, overflow_o); end
    op(0, 1, 0, 3'd1, 32'hdead, 32'd99, 32'd99);
    n_vec++; if (full_o !== 1'b1 || level_o !== 4'd8 || overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf full %b level %0d ovf %b want 1 8 1", full_o, level_o, overflow_o); end
    n_vec++; if (top_idx_o !== 3'd7 || top_addr_o !== 32'h207 || top_t_enter_o !== 32'sd21 || top_t_exit_o !== -32'sd7) begin n_err++; $display("FAIL ovf_top got %0d %h %0d %0d want 7 207 21 -7", top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o); end
    op(0, 1, 1, 3'd2, 32'h300, 32'd1, 32'd2);
    n_vec++; if (level_o !== 4'd8 || top_addr_o !== 32'h300 || pop_ack_o !== 1'b1) begin n_err++; $display("FAIL full_repl level %0d addr %h ack %b want 8 300 1", level_o, top_addr_o, pop_ack_o); end
    op(0, 0, 1, 0, 0, 0, 0);
    n_vec++; if (level_o !== 4'd7 || top_addr_o !== 32'h206 || top_idx_o !== 3'd6 || pop_ack_o !== 1'b1) begin n_err++; $display("FAIL pop_after_full level %0d addr %h idx %0d ack %b want 7 206 6 1", level_o, top_addr_o, top_idx_o, pop_ack_o); end
    n_vec++; if (overflow_o !== 1'b1 || full_o !== 1'b0) begin n_err++; $display("FAIL ovf_sticky ovf %b full %b want 1 0", overflow_o, full_o); end
    op(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (pop_ack_o !== 1'b0) begin n_err++; $display("FAIL ack_pulse got %b want 0", pop_ack_o); end
  endtask

  task automatic test_underflow();
    op(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (overflow_o !== 1'b0 || level_o !== 4'd0) begin n_err++; $display("FAIL clr_ovf ovf %b level %0d want 0 0", overflow_o, level_o); end
    op(0, 0, 1, 0, 0, 0, 0);
    n_vec++; if (underflow_o !== 1'b1 || pop_ack_o !== 1'b0 || level_o !== 4'd0) begin n_err++; $display("FAIL udf udf %b ack %b level %0d want 1 0 0", underflow_o, pop_ack_o, level_o); end
    op(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL udf_sticky got %b want 1", underflow_o); end
    op(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b want 0", underflow_o); end
  endtask

  task automatic test_replace();
    op(0, 1, 0, 3'd1, 32'hA0, 32'd1, 32'd2);
    op(0, 1, 0, 3'd2, 32'hB0, 32'd3, 32'd4);
    op(0, 1, 1, 3'd3, 32'hC0, 32'd5, 32'd6);
    n_vec++; if (level_o !== 4'd2 || pop_ack_o !== 1'b1) begin n_err++; $display("FAIL repl level %0d ack %b want 2 1", level_o, pop_ack_o); end
    n_vec++; if (top_idx_o !== 3'd3 || top_addr_o !== 32'hC0 || top_t_enter_o !== 32'sd5 || top_t_exit_o !== 32'sd6) begin n_err++; $display("FAIL repl_top got %0d %h %0d %0d want 3 c0 5 6", top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o); end
    op(0, 0, 1, 0, 0, 0, 0);
    n_vec++; if (level_o !== 4'd1 || top_idx_o !== 3'd1 || top_addr_o !== 32'hA0 || top_t_exit_o !== 32'sd2) begin n_err++; $display("FAIL repl_pop level %0d idx %0d addr %h tx %0d want 1 1 a0 2", level_o, top_idx_o, top_addr_o, top_t_exit_o); end
    op(0, 0, 1, 0, 0, 0, 0);
    n_vec++; if (level_o !== 4'd0 || empty_o !== 1'b1 || {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o} !== '0) begin n_err++; $display("FAIL pop_to_empty level %0d empty %b top %h want 0 1 0", level_o, empty_o, {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o}); end
    op(0, 1, 1, 3'd4, 32'hD0, 32'd7, 32'd8);
    n_vec++; if (level_o !== 4'd1 || pop_ack_o !== 1'b0 || underflow_o !== 1'b0 || top_addr_o !== 32'hD0) begin n_err++; $display("FAIL pushpop_empty level %0d ack %b udf %b addr %h want 1 0 0 d0", level_o, pop_ack_o, underflow_o, top_addr_o); end
  endtask

  task automatic test_async_reset();
    op(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op(0, 1, 0, 3'(i + 1), 32'h400 + 32'(i), 32'd1, 32'd1);
    n_vec++; if (level_o !== 4'd3) begin n_err++; $display("FAIL pre_rst level got %0d want 3", level_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_vec++; if (level_o !== 4'd0 || empty_o !== 1'b1 || top_addr_o !== 32'h0 || top_idx_o !== 3'd0) begin n_err++; $display("FAIL async_rst level %0d empty %b addr %h idx %0d want 0 1 0 0", level_o, empty_o, top_addr_o, top_idx_o); end
    @(posedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    op(0, 0, 1, 0, 0, 0, 0);
    n_vec++; if (underflow_o !== 1'b1 || pop_ack_o !== 1'b0 || level_o !== 4'd0) begin n_err++; $display("FAIL post_rst_pop udf %b ack %b level %0d want 1 0 0", underflow_o, pop_ack_o, level_o); end
  endtask

  task automatic test_clear_push();
    op(1, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, 3'd1, 32'h500, 32'd1, 32'd1);
    op(0, 1, 0, 3'd2, 32'h501, 32'd2, 32'd2);
    op(1, 1, 0, 3'd3, 32'h502, 32'd3, 32'd3);
    n_vec++; if (level_o !== 4'd0 || empty_o !== 1'b1 || {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o} !== '0) begin n_err++; $display("FAIL clr_push level %0d empty %b top %h want 0 1 0", level_o, empty_o, {top_idx_o, top_addr_o, top_t_enter_o, top_t_exit_o}); end
    op(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (level_o !== 4'd0 || pop_ack_o !== 1'b0) begin n_err++; $display("FAIL clr_hold level %0d ack %b want 0 0", level_o, pop_ack_o); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_fill_overflow();
    test_underflow();
    test_replace();
    test_async_reset();
    test_clear_push();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
